// File: rtl/riscv_pkg.sv
// Shared state encoding, funct3 codes and access-legality helper for the M-stage load/store unit.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only exist for loads; halves and words must be naturally aligned.
    function automatic logic lsuAccessLegal(input logic [2:0] funct3,
                                            input logic       isStore,
                                            input logic [1:0] offset);
        logic legal;
        legal = 1'b0;
        case (funct3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = !offset[0];
            F3_W:    legal = (offset == 2'b00);
            F3_BU:   legal = !isStore;
            F3_HU:   legal = !isStore && !offset[0];
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication, load byte/half extraction and extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] storeData_i,
    input  logic [31:0] loadWord_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] loadData_o
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{storeData_i[7:0]}};
            end
            2'b01: begin
                be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{storeData_i[15:0]}};
            end
            2'b10: begin
                be_o    = 4'b1111;
                wdata_o = storeData_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
            end
        endcase
    end

    assign loadByte = loadWord_i[{offset_i, 3'b000} +: 8];
    assign loadHalf = loadWord_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        loadData_o = 32'h0;
        case (funct3_i)
            F3_B:    loadData_o = {{24{loadByte[7]}}, loadByte};
            F3_H:    loadData_o = {{16{loadHalf[15]}}, loadHalf};
            F3_W:    loadData_o = loadWord_i;
            F3_BU:   loadData_o = {24'h0, loadByte};
            F3_HU:   loadData_o = {16'h0, loadHalf};
            default: loadData_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store engine: valid/ready data-memory port, pipeline stall, access-error flag and the
// MEM/WB load-data register.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              StallLSU,
    output logic              AccessErrM,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] ReadDataW
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] storeData_q;
    logic              isStore_q;
    logic [DATA_W-1:0] loadData_q;
    logic [DATA_W-1:0] readDataW_q, readDataW_d;

    logic              access;
    logic              legal;
    logic              startAccess;
    logic              accessErr;
    logic              stall;
    logic              reqValid;
    logic              loadCapture;
    logic [3:0]        alignBe;
    logic [31:0]       alignWdata;
    logic [31:0]       alignLoad;

    assign access = MemReadM | MemWriteM;
    assign legal  = lsuAccessLegal(Funct3M, MemWriteM, ALUResultM[1:0]);

    always_comb begin
        state_d     = state_q;
        startAccess = 1'b0;
        accessErr   = 1'b0;
        stall       = 1'b0;
        reqValid    = 1'b0;
        loadCapture = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && legal) begin
                    startAccess = 1'b1;
                    stall       = 1'b1;
                    state_d     = REQ;
                end else if (access) begin
                    accessErr = 1'b1;
                end
            end
            REQ: begin
                stall    = 1'b1;
                reqValid = 1'b1;
                if (dmem_req_ready) begin
                    state_d = isStore_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_rsp_valid) begin
                    loadCapture = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // DONE keeps the stall low so the pipeline advances; only a completed load reaches the W stage.
    assign readDataW_d = (state_q == DONE && !isStore_q) ? loadData_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            funct3_q    <= 3'b000;
            storeData_q <= '0;
            isStore_q   <= 1'b0;
            loadData_q  <= '0;
            readDataW_q <= '0;
        end else begin
            state_q <= state_d;
            if (startAccess) begin
                addr_q      <= ALUResultM;
                funct3_q    <= Funct3M;
                storeData_q <= WriteDataM;
                isStore_q   <= MemWriteM;
            end
            if (loadCapture) begin
                loadData_q <= alignLoad;
            end
            if (!stall) begin
                readDataW_q <= readDataW_d;
            end
        end
    end

    lsu_align u_align (
        .funct3_i   (funct3_q),
        .offset_i   (addr_q[1:0]),
        .storeData_i(storeData_q),
        .loadWord_i (dmem_rdata),
        .be_o       (alignBe),
        .wdata_o    (alignWdata),
        .loadData_o (alignLoad)
    );

    // The stall and error flags decode live inputs, so they are masked while reset is held.
    assign StallLSU       = rst_n & stall;
    assign AccessErrM     = rst_n & accessErr;
    assign dmem_req_valid = reqValid;
    assign dmem_we        = reqValid & isStore_q;
    assign dmem_be        = (reqValid && isStore_q) ? alignBe : 4'b0000;
    assign dmem_addr      = reqValid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wdata     = (reqValid && isStore_q) ? alignWdata : '0;
    assign ReadDataW      = readDataW_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven testbench for load_store_unit with a small valid/ready memory responder.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk;
    logic        rst_n;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallLSU;
    logic        AccessErrM;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic [31:0] ReadDataW;

    int tests;
    int failures;

    typedef struct {
        logic        isStore;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          readyDelay;
        logic        expErr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRead;
    } vec_t;

    vec_t vecs[20];

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MemReadM      (MemReadM),
        .MemWriteM     (MemWriteM),
        .Funct3M       (Funct3M),
        .ALUResultM    (ALUResultM),
        .WriteDataM    (WriteDataM),
        .StallLSU      (StallLSU),
        .AccessErrM    (AccessErrM),
        .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready),
        .dmem_we       (dmem_we),
        .dmem_be       (dmem_be),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata    (dmem_rdata),
        .ReadDataW     (ReadDataW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic isStore, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata, input int readyDelay,
                                   input logic expErr, input logic [3:0] expBe, input logic [31:0] expWdata,
                                   input logic [31:0] expRead);
        vec_t v;
        v.isStore    = isStore;
        v.f3         = f3;
        v.addr       = addr;
        v.wdata      = wdata;
        v.rdata      = rdata;
        v.readyDelay = readyDelay;
        v.expErr     = expErr;
        v.expBe      = expBe;
        v.expWdata   = expWdata;
        v.expRead    = expRead;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge that follows the DONE edge.
    task automatic applyStimulus(input vec_t v, input int idx, input logic [31:0] holdExp);
        int          waitCnt;
        int          stalls;
        int          expStalls;
        bit          respPending;
        bit          sawReq;
        bit          errSeen;
        bit          unstable;
        bit          done;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] ad1;
        logic        we1;
        logic [31:0] heldRead;
        string       tag;

        tag         = $sformatf("vec%0d", idx);
        waitCnt     = 0;
        stalls      = 0;
        respPending = 0;
        sawReq      = 0;
        errSeen     = 0;
        unstable    = 0;
        done        = 0;
        be1         = 4'h0;
        wd1         = 32'h0;
        ad1         = 32'h0;
        we1         = 1'b0;
        heldRead    = holdExp;

        MemReadM   = !v.isStore;
        MemWriteM  = v.isStore;
        Funct3M    = v.f3;
        ALUResultM = v.addr;
        WriteDataM = v.wdata;
        dmem_rdata = v.rdata;

        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            dmem_req_ready = dmem_req_valid && (waitCnt >= v.readyDelay);
            dmem_rsp_valid = respPending;
            #1;
            if (dmem_rsp_valid) respPending = 0;
            if (dmem_req_valid && dmem_req_ready && !v.isStore) respPending = 1;
            if (StallLSU) begin
                stalls++;
                if (ReadDataW !== holdExp) heldRead = ReadDataW;
            end
            if (AccessErrM) errSeen = 1;
            if (dmem_req_valid) begin
                if (!sawReq) begin
                    be1 = dmem_be;
                    wd1 = dmem_wdata;
                    ad1 = dmem_addr;
                    we1 = dmem_we;
                end else if (dmem_be !== be1 || dmem_wdata !== wd1 || dmem_addr !== ad1 || dmem_we !== we1) begin
                    unstable = 1;
                end
                sawReq = 1;
                if (!dmem_req_ready) waitCnt++;
            end
            if (!StallLSU) done = 1;
        end

        @(negedge clk);
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        #1;

        expStalls = v.expErr ? 0 : ((v.isStore ? 2 : 3) + v.readyDelay);
        checkOutput({tag, "_finished"}, 32'(done), 32'd1);
        checkOutput({tag, "_err"}, 32'(errSeen), 32'(v.expErr));
        checkOutput({tag, "_stallCycles"}, 32'(stalls), 32'(expStalls));
        checkOutput({tag, "_reqSeen"}, 32'(sawReq), 32'(!v.expErr));
        if (sawReq) begin
            checkOutput({tag, "_we"}, 32'(we1), 32'(v.isStore));
            checkOutput({tag, "_be"}, 32'(be1), 32'(v.expBe));
            checkOutput({tag, "_addr"}, ad1, {v.addr[31:2], 2'b00});
            checkOutput({tag, "_reqStable"}, 32'(unstable), 32'd0);
            if (v.isStore) checkOutput({tag, "_wdata"}, wd1, v.expWdata);
        end
        if (!v.expErr) checkOutput({tag, "_holdWhileStalled"}, heldRead, holdExp);
        checkOutput({tag, "_noRetrigger"}, 32'(dmem_req_valid), 32'd0);
        checkOutput({tag, "_ReadDataW"}, ReadDataW, v.expRead);
    endtask

    initial begin
        logic [31:0] hold;

        tests          = 0;
        failures       = 0;
        rst_n          = 1'b0;
        MemReadM       = 1'b0;
        MemWriteM      = 1'b0;
        Funct3M        = 3'b000;
        ALUResultM     = 32'h0;
        WriteDataM     = 32'h0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;

        vecs[0]  = mkVec(0, W,     32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'h0, 32'h0,        32'hDEADBEEF);
        vecs[1]  = mkVec(0, B,     32'h103, 32'h0,        32'h80AA55CC, 0, 0, 4'h0, 32'h0,        32'hFFFFFF80);
        vecs[2]  = mkVec(0, BU,    32'h103, 32'h0,        32'h80AA55CC, 0, 0, 4'h0, 32'h0,        32'h00000080);
        vecs[3]  = mkVec(1, H,     32'h102, 32'h1234ABCD, 32'h0,        2, 0, 4'hC, 32'hABCDABCD, 32'h0);
        vecs[4]  = mkVec(0, W,     32'h101, 32'h0,        32'h0,        0, 1, 4'h0, 32'h0,        32'h0);
        vecs[5]  = mkVec(1, B,     32'h201, 32'h000000A5, 32'h0,        0, 0, 4'h2, 32'hA5A5A5A5, 32'h0);
        vecs[6]  = mkVec(0, H,     32'h102, 32'h0,        32'h80017FFF, 0, 0, 4'h0, 32'h0,        32'hFFFF8001);
        vecs[7]  = mkVec(0, HU,    32'h100, 32'h0,        32'h1234F00D, 0, 0, 4'h0, 32'h0,        32'h0000F00D);
        vecs[8]  = mkVec(0, H,     32'h100, 32'h0,        32'h00007FFF, 0, 0, 4'h0, 32'h0,        32'h00007FFF);
        vecs[9]  = mkVec(1, W,     32'h10C, 32'hCAFEF00D, 32'h0,        1, 0, 4'hF, 32'hCAFEF00D, 32'h0);
        vecs[10] = mkVec(1, H,     32'h101, 32'h00001111, 32'h0,        0, 1, 4'h0, 32'h0,        32'h0);
        vecs[11] = mkVec(0, B,     32'h101, 32'h0,        32'h00007F00, 0, 0, 4'h0, 32'h0,        32'h0000007F);
        vecs[12] = mkVec(0, 3'b011, 32'h100, 32'h0,       32'h0,        0, 1, 4'h0, 32'h0,        32'h0);
        vecs[13] = mkVec(1, BU,    32'h100, 32'h000000FF, 32'h0,        0, 1, 4'h0, 32'h0,        32'h0);
        vecs[14] = mkVec(1, B,     32'h200, 32'h12345678, 32'h0,        0, 0, 4'h1, 32'h78787878, 32'h0);
        vecs[15] = mkVec(0, HU,    32'h202, 32'h0,        32'h80010000, 0, 0, 4'h0, 32'h0,        32'h00008001);
        vecs[16] = mkVec(0, B,     32'h102, 32'h0,        32'h00FE0000, 0, 0, 4'h0, 32'h0,        32'hFFFFFFFE);
        vecs[17] = mkVec(0, W,     32'h104, 32'h0,        32'h0BADF00D, 1, 0, 4'h0, 32'h0,        32'h0BADF00D);
        vecs[18] = mkVec(1, H,     32'h100, 32'h0000BEEF, 32'h0,        0, 0, 4'h3, 32'hBEEFBEEF, 32'h0);
        vecs[19] = mkVec(1, B,     32'h203, 32'h000000C3, 32'h0,        0, 0, 4'h8, 32'hC3C3C3C3, 32'h0);

        // Reset state, with a legal load presented so that masking of the stall is exercised.
        repeat (2) @(negedge clk);
        MemReadM   = 1'b1;
        Funct3M    = W;
        ALUResultM = 32'h100;
        #1;
        checkOutput("reset_StallLSU", 32'(StallLSU), 32'd0);
        checkOutput("reset_AccessErrM", 32'(AccessErrM), 32'd0);
        checkOutput("reset_req_valid", 32'(dmem_req_valid), 32'd0);
        checkOutput("reset_we_be", {27'h0, dmem_we, dmem_be}, 32'h0);
        checkOutput("reset_addr", dmem_addr, 32'h0);
        checkOutput("reset_ReadDataW", ReadDataW, 32'h0);
        MemReadM = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        // Vectors run back to back, so each one also checks the previous result is held while stalled.
        hold = 32'h0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i], i, hold);
            hold = vecs[i].expRead;
        end
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;

        // Misaligned word load: single-cycle error, no request, no stall.
        @(negedge clk);
        MemReadM   = 1'b1;
        Funct3M    = W;
        ALUResultM = 32'h101;
        #1;
        checkOutput("err_pulse_high", 32'(AccessErrM), 32'd1);
        checkOutput("err_no_stall", 32'(StallLSU), 32'd0);
        @(negedge clk);
        MemReadM = 1'b0;
        #1;
        checkOutput("err_pulse_low", 32'(AccessErrM), 32'd0);
        checkOutput("err_no_request", 32'(dmem_req_valid), 32'd0);

        // Reset asserted while a load waits for its response; a late response must be dropped.
        @(negedge clk);
        applyStimulus(vecs[0], 100, 32'h0);
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        Funct3M    = W;
        ALUResultM = 32'h104;
        dmem_rdata = 32'h55555555;
        #1;
        checkOutput("rstwait_idle_stall", 32'(StallLSU), 32'd1);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        #1;
        checkOutput("rstwait_req_valid", 32'(dmem_req_valid), 32'd1);
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #1;
        checkOutput("rstwait_wait_stall", 32'(StallLSU), 32'd1);
        checkOutput("rstwait_wait_hold", ReadDataW, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        checkOutput("rstwait_stall_cleared", 32'(StallLSU), 32'd0);
        checkOutput("rstwait_req_cleared", 32'(dmem_req_valid), 32'd0);
        checkOutput("rstwait_ReadDataW_cleared", ReadDataW, 32'h0);
        MemReadM = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_rsp_valid = 1'b1;
        #1;
        checkOutput("late_rsp_no_stall", 32'(StallLSU), 32'd0);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        #1;
        checkOutput("late_rsp_ReadDataW", ReadDataW, 32'h0);
        checkOutput("late_rsp_no_request", 32'(dmem_req_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("late_rsp_ReadDataW_after", ReadDataW, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
